// File: rtl/bcd_pkg.sv
// bcd_pkg: FSM states, blank digit code and DIGITS sizing helper shared by the bin2bcd_seq converter
package bcd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_t;
  localparam logic [3:0] BCD_BLANK = 4'b1111;
  function automatic int digits_for_width(input int w);
    longint p = 1;
    int d = 0;
    for (int i = 0; i < 12; i++)
      if (p <= (longint'(1) << w)) begin
        p = p * 10;
        d++;
      end
    return d;
  endfunction
endpackage

// File: rtl/bcd_add3_nibble.sv
// bcd_add3_nibble: double-dabble cell, d (4b in) -> q (4b out) = d>=5 ? d+3 : d
module bcd_add3_nibble (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock signed/unsigned binary to BCD; in clk reset start bin is_signed lz_blank, out busy done bcd neg
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  input  logic                is_signed,
  input  logic                lz_blank,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  state_t state, next;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0] scr, adj, blk;
  logic [CW-1:0] cnt;
  logic neg_r, lz_r, lead, neg_in;
  if (WIDTH < 4 || WIDTH > 32 || DIGITS < digits_for_width(WIDTH)) begin : g_bad
    $error("bin2bcd_seq: WIDTH out of range or DIGITS too small for WIDTH");
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    bcd_add3_nibble u_add3 (.d(scr[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  always_comb begin
    next   = state;
    busy   = state != ST_IDLE;
    neg_in = is_signed & bin[WIDTH-1];
    next   = (state == ST_IDLE)  ? (start ? ST_SHIFT : ST_IDLE) :
             (state == ST_SHIFT) ? ((cnt == CW'(1)) ? ST_FINISH : ST_SHIFT) : ST_IDLE;
  end
  always_comb begin
    blk  = scr;
    lead = lz_r;
    for (int i = DIGITS - 1; i > 0; i--)
      if (lead && scr[4*i +: 4] == 4'd0) blk[4*i +: 4] = BCD_BLANK;
      else lead = 1'b0;
  end
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= next;
  always_ff @(posedge clk) begin
    if (reset) begin
      mag   <= '0;
      scr   <= '0;
      cnt   <= '0;
      neg_r <= 1'b0;
      lz_r  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
    end else begin
      done <= state == ST_FINISH;
      if (state == ST_IDLE && start) begin
        mag   <= neg_in ? -bin : bin;
        neg_r <= neg_in;
        lz_r  <= lz_blank;
        scr   <= '0;
        cnt   <= CW'(WIDTH);
      end
      if (state == ST_SHIFT) begin
        scr <= {adj[BW-2:0], mag[WIDTH-1]};
        mag <= {mag[WIDTH-2:0], 1'b0};
        cnt <= cnt - 1'b1;
      end
      if (state == ST_FINISH) begin
        bcd <= blk;
        neg <= neg_r & (|scr);
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;
  localparam int W = 16;
  localparam int D = 5;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0, lz_blank = 1'b0;
  logic [W-1:0] bin = '0;
  logic busy, done, neg;
  logic [4*D-1:0] bcd;
  typedef struct {
    logic [4*D-1:0] b;
    logic           n;
  } exp_t;
  typedef struct {
    logic [W-1:0]   bin;
    logic           sgn;
    logic           lz;
    logic [4*D-1:0] eb;
    logic           en;
  } vec_t;
  exp_t q[$];
  vec_t vecs[11];
  int checks = 0, failures = 0, dones = 0;
  always #5 clk = ~clk;
  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .is_signed(is_signed),
    .lz_blank(lz_blank), .busy(busy), .done(done), .bcd(bcd), .neg(neg)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (done) begin
      exp_t e;
      dones++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got bcd %h with empty scoreboard", bcd);
      end else begin
        e = q.pop_front();
        chk("bcd", 32'(bcd), 32'(e.b));
        chk("neg", 32'(neg), 32'(e.n));
      end
    end
  task automatic launch(input logic [W-1:0] b, input logic s, input logic l);
    bin = b;
    is_signed = s;
    lz_blank = l;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      bc += int'(busy);
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done within 40 cycles");
    end
  endtask
  initial begin
    int lat, bc, n0, bad;
    vecs = '{
      '{16'd12345, 1'b0, 1'b0, 20'h12345, 1'b0},
      '{16'd0,     1'b0, 1'b1, 20'hFFFF0, 1'b0},
      '{16'd907,   1'b0, 1'b1, 20'hFF907, 1'b0},
      '{16'd65535, 1'b0, 1'b0, 20'h65535, 1'b0},
      '{16'h8000,  1'b1, 1'b0, 20'h32768, 1'b1},
      '{16'hFFFF,  1'b1, 1'b0, 20'h00001, 1'b1},
      '{16'h7FFF,  1'b1, 1'b0, 20'h32767, 1'b0},
      '{16'd100,   1'b1, 1'b1, 20'hFF100, 1'b0},
      '{16'hFF9C,  1'b1, 1'b1, 20'hFF100, 1'b1},
      '{16'h8000,  1'b0, 1'b1, 20'h32768, 1'b0},
      '{16'd5,     1'b0, 1'b1, 20'hFFFF5, 1'b0}
    };
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_bcd", 32'(bcd), 0);
    chk("reset_neg", 32'(neg), 0);
    reset = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      q.push_back('{vecs[i].eb, vecs[i].en});
      launch(vecs[i].bin, vecs[i].sgn, vecs[i].lz);
      wait_done(lat, bc);
      chk("latency", lat, W + 2);
      chk("busy_cycles", bc, W + 1);
      chk("busy_in_done", 32'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
    end
    n0 = dones;
    q.push_back('{20'h00042, 1'b0});
    launch(16'd42, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    bin = 16'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = '0;
    wait_done(lat, bc);
    repeat (W + 4) @(negedge clk);
    chk("ignored_start_dones", dones - n0, 1);
    launch(16'd1234, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    bin = 16'd777;
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd), 0);
    chk("abort_neg", 32'(neg), 0);
    n0 = dones;
    repeat (W + 4) @(negedge clk);
    chk("abort_no_done", dones - n0, 0);
    q.push_back('{20'h00500, 1'b0});
    launch(16'd500, 1'b0, 1'b0);
    wait_done(lat, bc);
    chk("after_abort_latency", lat, W + 2);
    @(negedge clk);
    q.push_back('{20'h00002, 1'b0});
    launch(16'd2, 1'b0, 1'b0);
    wait_done(lat, bc);
    q.push_back('{20'h00001, 1'b0});
    launch(16'd1, 1'b0, 1'b0);
    lat = 0;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (bcd !== 20'h00002) bad++;
    end
    chk("b2b_period", lat, W + 2);
    chk("b2b_no_intermediate", bad, 0);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Supplies the packed 4-bit BCD digits consumed by the seven-segment decoders on the board display path.
- Supports signed input: a sign flag drives a minus indicator, and the digits carry the magnitude.
- Optional leading-zero blanking emits code 4'b1111, which the segment decoder renders as all segments off.

Parameters:
WIDTH, 16, binary input width in bits (range 4..32)
DIGITS, 5, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH (16 -> 5, 8 -> 3, 32 -> 10)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request conversion; sampled only in IDLE
bin  in  WIDTH  binary operand; captured on accepted start
is_signed  in  1  treat bin as two's complement; captured with bin
lz_blank  in  1  blank leading zeros; captured with bin
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse when bcd/neg are updated
bcd  out  4*DIGITS  packed digits, digit 0 (units) in bits [3:0]
neg  out  1  result is negative (signed mode only)

Behaviour:
- Reset values: busy=0, done=0, bcd=all zeros, neg=0, FSM=IDLE, shift counter=0.
- Reset is synchronous. It takes priority over start and aborts any conversion in progress. No done pulse is produced for an aborted conversion, and the outputs return to their reset values.
- FSM states:
  - IDLE: busy=0. On start=1:
    - mag = (is_signed && bin[WIDTH-1]) ? -bin : bin, computed at WIDTH bits as an unsigned result. -2^(WIDTH-1) maps to 2^(WIDTH-1).
    - neg_r = is_signed && bin[WIDTH-1].
    - Latch lz_blank, clear the scratch BCD register, set cnt=WIDTH, go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - Every scratch nibble >= 5 gets +3 (combinational).
    - Then {scratch, mag} shifts left by 1.
    - cnt decrements. When cnt reaches 1 in this cycle, go to FINISH.
    - Exactly WIDTH cycles are spent in SHIFT.
  - FINISH: busy=1.
    - bcd <= the scratch register with blanking applied.
    - neg <= neg_r.
    - done <= 1 on the next edge, FSM -> IDLE.
- Latency: start accepted at edge N. busy is high at edges N+1..N+WIDTH+1. done and the new bcd are visible after edge N+WIDTH+2, for exactly one cycle for done. The next start is accepted in the cycle done is high, which gives back-to-back throughput of one conversion per WIDTH+2 cycles.
- start while busy=1 is ignored; it is not queued. bin, is_signed and lz_blank may change freely after accept.
- bcd and neg hold their last values between conversions. They never show intermediate values.
- Blanking, applied in FINISH only when the latched lz_blank=1:
  - Scan from digit DIGITS-1 downward. Every zero digit above the most-significant nonzero digit becomes 4'b1111.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- neg for a value of 0 is always 0, including signed -0, which is unreachable anyway.
- Unsigned mode: bin[WIDTH-1] is data, and neg=0.
- Arithmetic: the add-3 is applied per nibble at 4 bits. No carry out of a nibble is possible because nibble values are <= 9 before the add. There is no overflow path given the DIGITS constraint.

Decomposition:
- Shared package bcd_pkg holds:
  - FSM state encoding ST_IDLE/ST_SHIFT/ST_FINISH.
  - Constant BCD_BLANK = 4'b1111.
  - Function digits_for_width(w), used by a parameter sanity check (elaboration error if DIGITS is too small).
- One sub-module, bcd_add3_nibble: a combinational 4-bit ">=5 then +3" cell, instantiated DIGITS times via generate.
- Blanking and FSM stay in the top.

Test Plan:
- Reset, then start with bin=16'd12345, unsigned, lz_blank=0 -> done after 18 cycles; bcd=20'h12345, neg=0; busy high exactly 17 cycles.
- bin=16'd0, lz_blank=1 -> bcd=20'hFFFF0. Then bin=16'd907, lz_blank=1 -> bcd=20'hFF907. Then bin=16'd65535, lz_blank=0 -> bcd=20'h65535.
- Signed mode: bin=16'h8000 -> bcd=20'h32768, neg=1. bin=16'hFFFF -> bcd=20'h00001, neg=1. bin=16'h7FFF -> bcd=20'h32767, neg=0.
- Accept 16'd42, pulse start with 16'd99 at cycle 5 of SHIFT -> result 00042. The second start is ignored, and a single done pulse is produced.
- Reset asserted mid-SHIFT at cycle 8 with start also high -> no done pulse, bcd=0, busy=0 next cycle. A subsequent start with 16'd500 gives bcd=20'h00500.
- Back-to-back: assert start in the done cycle with 16'd1 after 16'd2 -> the second done arrives WIDTH+2 cycles later; bcd steps 00002 -> 00001 with no intermediate value.
